// File: rtl/mesi_snoop_ctrl_if.sv
// Bus-side interface of the MESI snoop controller: snoop request/response,
// memory write-back handshake and the processor-side local line update port.
// The master modport is the bus/processor side, the slave modport is the
// controller itself.
interface mesi_snoop_ctrl_if #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 8
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int ADDR_W = TAG_W + IDX_W;

  logic              SnoopValid;
  logic              SnoopReady;
  logic [1:0]        SnoopOp;
  logic [ADDR_W-1:0] SnoopAddr;
  logic              SnoopDone;
  logic              SnoopHit;
  logic              WbReq;
  logic [ADDR_W-1:0] WbAddr;
  logic              WbAck;
  logic              LocalWe;
  logic [IDX_W-1:0]  LocalIdx;
  logic [TAG_W-1:0]  LocalTag;
  logic [1:0]        LocalState;
  logic              LocalReady;

  modport master (
    output SnoopValid, SnoopOp, SnoopAddr, WbAck,
           LocalWe, LocalIdx, LocalTag, LocalState,
    input  SnoopReady, SnoopDone, SnoopHit, WbReq, WbAddr, LocalReady
  );

  modport slave (
    input  SnoopValid, SnoopOp, SnoopAddr, WbAck,
           LocalWe, LocalIdx, LocalTag, LocalState,
    output SnoopReady, SnoopDone, SnoopHit, WbReq, WbAddr, LocalReady
  );
endinterface

// File: rtl/mesi_snoop_ctrl.sv
// Snoop-side MESI controller for a direct-mapped cache of NUM_LINES lines.
// Holds per-line tag and MESI state, serves one bus snoop at a time
// (IDLE -> LOOKUP -> [WB] -> RESP) and accepts processor-side line updates
// on any line not owned by the snoop in flight.
// Optional hit / write-back counters: define MESI_SNOOP_STATS_EN.
module mesi_snoop_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 8
) (
  input logic Clock,
  input logic Reset,
  mesi_snoop_ctrl_if.slave bus
`ifdef MESI_SNOOP_STATS_EN
  ,
  output logic [15:0] HitCount,
  output logic [15:0] WbCount
`endif
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int ADDR_W = TAG_W + IDX_W;

  // MESI line states
  localparam logic [1:0] MESI_E = 2'b00;
  localparam logic [1:0] MESI_I = 2'b01;
  localparam logic [1:0] MESI_S = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  // Snoop opcodes; 00 is illegal and behaves as a miss
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]       fsmState;
  logic [1:0]       latOp;
  logic [TAG_W-1:0] latTag;
  logic [IDX_W-1:0] latIdx;
  logic             hitReg;

  logic [TAG_W-1:0] lineTag   [NUM_LINES];
  logic [1:0]       lineState [NUM_LINES];

  logic       lookupHit;
  logic       needWb;
  logic       applyUpdate;
  logic [1:0] nextMesi;

  // Hit detection and next MESI state for the latched snoop line
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nextMesi    = lineState[latIdx];
    lookupHit   = (latOp != OP_NONE) && (lineTag[latIdx] == latTag) &&
                  (lineState[latIdx] != MESI_I);
    needWb      = lookupHit && (lineState[latIdx] == MESI_M) &&
                  ((latOp == OP_RD) || (latOp == OP_WR));
    applyUpdate = ((fsmState == ST_LOOKUP) && lookupHit && !needWb) ||
                  ((fsmState == ST_WB) && bus.WbAck);
    case (latOp)
      OP_RD:         nextMesi = MESI_S;
      OP_WR, OP_INV: nextMesi = MESI_I;
      default:       nextMesi = lineState[latIdx];
    endcase
  end

  assign bus.SnoopReady = (fsmState == ST_IDLE);
  assign bus.SnoopDone  = (fsmState == ST_RESP);
  assign bus.SnoopHit   = (fsmState == ST_RESP) && hitReg;
  assign bus.WbReq      = (fsmState == ST_WB);
  assign bus.WbAddr     = {latTag, latIdx};
  // The line owned by an in-flight snoop is locked against local updates
  assign bus.LocalReady = (fsmState == ST_IDLE) || (bus.LocalIdx != latIdx);

  // Snoop sequencing: accept, look up, optional write-back, respond
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      fsmState <= ST_IDLE;
      latOp    <= OP_NONE;
      latTag   <= '0;
      latIdx   <= '0;
      hitReg   <= 1'b0;
    end else begin
      case (fsmState)
        ST_IDLE: begin
          if (bus.SnoopValid) begin
            latOp    <= bus.SnoopOp;
            latTag   <= bus.SnoopAddr[ADDR_W-1:IDX_W];
            latIdx   <= bus.SnoopAddr[IDX_W-1:0];
            fsmState <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hitReg   <= lookupHit;
          fsmState <= needWb ? ST_WB : ST_RESP;
        end
        ST_WB: begin
          if (bus.WbAck) fsmState <= ST_RESP;
        end
        default: fsmState <= ST_IDLE;
      endcase
    end
  end

  // Line tag/state storage: local updates and snoop transitions
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the line array is reset explicitly because every line must start Invalid with tag 0.
      for (int i = 0; i < NUM_LINES; i++) begin
        lineTag[i]   <= '0;
        lineState[i] <= MESI_I;
      end
    end else begin
      if (bus.LocalWe && bus.LocalReady) begin
        lineTag[bus.LocalIdx]   <= bus.LocalTag;
        lineState[bus.LocalIdx] <= bus.LocalState;
      end
      if (applyUpdate) lineState[latIdx] <= nextMesi;
    end
  end

`ifdef MESI_SNOOP_STATS_EN
  // Saturating hit and write-back counters
  always_ff @(posedge Clock) begin
    if (Reset) begin
      HitCount <= '0;
      WbCount  <= '0;
    end else begin
      if (bus.SnoopDone && bus.SnoopHit && (HitCount != 16'hFFFF))
        HitCount <= HitCount + 16'd1;
      if (bus.WbReq && bus.WbAck && (WbCount != 16'hFFFF))
        WbCount <= WbCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Self-checking bench for mesi_snoop_ctrl: a table of single-snoop vectors
// (optional local write, snoop, expected hit / latency / write-back length /
// final line state) plus hand-written sequences for local writes during a
// write-back and reset during a write-back.
module tb_mesi_snoop_ctrl;
  localparam int NUM_LINES = 4;
  localparam int TAG_W     = 8;
  localparam int IDX_W     = 2;
  localparam int ADDR_W    = TAG_W + IDX_W;

  localparam logic [1:0] E = 2'b00, I = 2'b01, S = 2'b10, M = 2'b11;
  localparam logic [1:0] OP_NONE = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_INV = 2'b11;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mesi_snoop_ctrl_if #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) bus ();

`ifdef MESI_SNOOP_STATS_EN
  logic [15:0] HitCount;
  logic [15:0] WbCount;
`endif

  mesi_snoop_ctrl #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
`ifdef MESI_SNOOP_STATS_EN
    ,
    .HitCount (HitCount),
    .WbCount  (WbCount)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // lwMode: 0 no local write, 1 local write before the snoop, 2 same cycle as accept
  typedef struct {
    int               lwMode;
    logic [IDX_W-1:0] lwIdx;
    logic [TAG_W-1:0] lwTag;
    logic [1:0]       lwState;
    logic [1:0]       op;
    logic [ADDR_W-1:0] addr;
    int               ackDelay;
    logic             expHit;
    int               expWb;
    logic [1:0]       expState;
  } vec_t;

  vec_t vecs [10];

  task automatic localWrite(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                            input logic [1:0] st, input string name);
    @(negedge Clock);
    bus.LocalWe    = 1'b1;
    bus.LocalIdx   = idx;
    bus.LocalTag   = tg;
    bus.LocalState = st;
    #1;
    check({name, "_lready"}, bus.LocalReady, 1);
    @(negedge Clock);
    bus.LocalWe = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input int k);
    int  n;
    int  wbCnt;
    int  wbAddrBad;
    bit  done;
    logic hitSeen;
    logic [IDX_W-1:0] idx;
    idx = v.addr[IDX_W-1:0];
    if (v.lwMode == 1) localWrite(v.lwIdx, v.lwTag, v.lwState, $sformatf("v%0d", k));
    @(negedge Clock);
    check($sformatf("v%0d_ready", k), bus.SnoopReady, 1);
    bus.SnoopValid = 1'b1;
    bus.SnoopOp    = v.op;
    bus.SnoopAddr  = v.addr;
    if (v.lwMode == 2) begin
      bus.LocalWe    = 1'b1;
      bus.LocalIdx   = v.lwIdx;
      bus.LocalTag   = v.lwTag;
      bus.LocalState = v.lwState;
    end
    n = 0; wbCnt = 0; wbAddrBad = 0; done = 0; hitSeen = 1'b0;
    while (!done && n < 40) begin
      @(negedge Clock);
      n++;
      bus.SnoopValid = 1'b0;
      bus.LocalWe    = 1'b0;
      if (bus.WbReq) begin
        wbCnt++;
        if (bus.WbAddr !== v.addr) wbAddrBad++;
        bus.WbAck = (wbCnt == v.ackDelay + 1);
      end else begin
        bus.WbAck = 1'b0;
      end
      if (bus.SnoopDone) begin
        done    = 1;
        hitSeen = bus.SnoopHit;
      end
    end
    bus.WbAck = 1'b0;
    check($sformatf("v%0d_done_seen", k), done, 1);
    check($sformatf("v%0d_latency", k), n, 2 + v.expWb);
    check($sformatf("v%0d_hit", k), hitSeen, v.expHit);
    check($sformatf("v%0d_wb_cycles", k), wbCnt, v.expWb);
    check($sformatf("v%0d_wb_addr_bad", k), wbAddrBad, 0);
    @(negedge Clock);
    check($sformatf("v%0d_done_pulse", k), bus.SnoopDone, 0);
    check($sformatf("v%0d_state", k), dut.lineState[idx], v.expState);
  endtask

  initial begin
    int n;
    bus.SnoopValid = 0; bus.SnoopOp = 0; bus.SnoopAddr = 0; bus.WbAck = 0;
    bus.LocalWe = 0; bus.LocalIdx = 0; bus.LocalTag = 0; bus.LocalState = 0;

    //            mode idx   tag    st  op       addr             ack hit wb state
    vecs[0] = '{0, 2'd0, 8'h00, I, OP_RD,   {8'h12, 2'd1}, 0, 1'b0, 0, I};
    vecs[1] = '{2, 2'd2, 8'h34, E, OP_RD,   {8'h34, 2'd2}, 0, 1'b1, 0, S};
    vecs[2] = '{1, 2'd0, 8'h01, S, OP_INV,  {8'h02, 2'd0}, 0, 1'b0, 0, S};
    vecs[3] = '{0, 2'd0, 8'h00, I, OP_INV,  {8'h01, 2'd0}, 0, 1'b1, 0, I};
    vecs[4] = '{1, 2'd1, 8'h77, M, OP_INV,  {8'h77, 2'd1}, 0, 1'b1, 0, I};
    vecs[5] = '{1, 2'd2, 8'h34, S, OP_WR,   {8'h34, 2'd2}, 0, 1'b1, 0, I};
    vecs[6] = '{1, 2'd0, 8'h55, M, OP_RD,   {8'h55, 2'd0}, 0, 1'b1, 1, S};
    vecs[7] = '{1, 2'd3, 8'hA5, E, OP_NONE, {8'hA5, 2'd3}, 0, 1'b0, 0, E};
    vecs[8] = '{1, 2'd3, 8'hA5, M, OP_WR,   {8'hA5, 2'd3}, 3, 1'b1, 4, I};
    vecs[9] = '{0, 2'd0, 8'h00, I, OP_RD,   {8'hA5, 2'd3}, 0, 1'b0, 0, I};

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_ready", bus.SnoopReady, 1);
    check("rst_done", bus.SnoopDone, 0);
    check("rst_hit", bus.SnoopHit, 0);
    check("rst_wbreq", bus.WbReq, 0);
    check("rst_wbaddr", bus.WbAddr, 0);
    Reset = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      check($sformatf("rst_state%0d", i), dut.lineState[i], I);
      check($sformatf("rst_tag%0d", i), dut.lineTag[i], 0);
    end

    // WbAck with no write-back pending is ignored
    @(negedge Clock);
    bus.WbAck = 1'b1;
    repeat (2) @(negedge Clock);
    check("stray_ack_ready", bus.SnoopReady, 1);
    check("stray_ack_wbreq", bus.WbReq, 0);
    bus.WbAck = 1'b0;

    for (int k = 0; k < 10; k++) runVec(vecs[k], k);

    // Local writes while a write-back holds line 3
    localWrite(2'd3, 8'h3C, M, "seqA");
    @(negedge Clock);
    bus.SnoopValid = 1'b1; bus.SnoopOp = OP_WR; bus.SnoopAddr = {8'h3C, 2'd3};
    @(negedge Clock);
    bus.SnoopValid = 1'b0;
    @(negedge Clock);
    check("seqA_wbreq", bus.WbReq, 1);
    bus.LocalWe = 1'b1; bus.LocalIdx = 2'd3; bus.LocalTag = 8'h99; bus.LocalState = E;
    #1;
    check("seqA_same_lready", bus.LocalReady, 0);
    @(negedge Clock);
    bus.LocalIdx = 2'd1; bus.LocalTag = 8'h42; bus.LocalState = E;
    #1;
    check("seqA_other_lready", bus.LocalReady, 1);
    @(negedge Clock);
    bus.LocalWe = 1'b0;
    check("seqA_l1_tag", dut.lineTag[1], 8'h42);
    check("seqA_l1_state", dut.lineState[1], E);
    check("seqA_l3_tag", dut.lineTag[3], 8'h3C);
    check("seqA_l3_state_pending", dut.lineState[3], M);
    check("seqA_wbreq_held", bus.WbReq, 1);
    check("seqA_wbaddr", bus.WbAddr, {8'h3C, 2'd3});
    bus.WbAck = 1'b1;
    @(negedge Clock);
    bus.WbAck = 1'b0;
    check("seqA_done", bus.SnoopDone, 1);
    check("seqA_hit", bus.SnoopHit, 1);
    check("seqA_l3_state", dut.lineState[3], I);

    // Reset during a write-back
    localWrite(2'd2, 8'h10, M, "seqB");
    @(negedge Clock);
    bus.SnoopValid = 1'b1; bus.SnoopOp = OP_WR; bus.SnoopAddr = {8'h10, 2'd2};
    n = 0;
    do begin
      @(negedge Clock);
      bus.SnoopValid = 1'b0;
      n++;
    end while (!bus.WbReq && n < 20);
    check("seqB_wbreq", bus.WbReq, 1);
    Reset = 1'b1;
    @(negedge Clock);
    check("seqB_rst_wbreq", bus.WbReq, 0);
    check("seqB_rst_ready", bus.SnoopReady, 1);
    check("seqB_rst_done", bus.SnoopDone, 0);
    Reset = 1'b0;
    for (int i = 0; i < NUM_LINES; i++)
      check($sformatf("seqB_state%0d", i), dut.lineState[i], I);
`ifdef MESI_SNOOP_STATS_EN
    check("seqB_hitcount", HitCount, 0);
    check("seqB_wbcount", WbCount, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
